// File: rtl/gearbox_pkg.sv
// Shared types for the electronic gearbox: quadrature states, pulse FSM states,
// count directions and the Gray-step classifier.
package gearbox_pkg;

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q10 = 2'b10;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q01 = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } pulse_state_e;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_FWD,
    DIR_REV,
    DIR_ILLEGAL
  } dir_e;

  // {A,B} pairs; A leading B walks Q00->Q10->Q11->Q01->Q00.
  function automatic dir_e quad_dir(input logic [1:0] prev, input logic [1:0] cur);
    dir_e d;
    d = DIR_NONE;
    if (prev == cur) begin
      d = DIR_NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      d = DIR_ILLEGAL;
    end else begin
      case (prev)
        Q00:     d = (cur == Q10) ? DIR_FWD : DIR_REV;
        Q10:     d = (cur == Q11) ? DIR_FWD : DIR_REV;
        Q11:     d = (cur == Q01) ? DIR_FWD : DIR_REV;
        default: d = (cur == Q00) ? DIR_FWD : DIR_REV;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/gearbox_quad_decoder.sv
// Quadrature front end: 2-FF synchronisers, baseline priming and Gray decode
// into single-cycle up/down count strobes.
module gearbox_quad_decoder
  import gearbox_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic phase_a,
  input  logic phase_b,
  output logic inc_c,
  output logic dec_c
);

  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] base;
  logic       primed;
  dir_e       dir_c;

  // Baseline follows the synced pair every clock, so illegal jumps re-anchor it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 2'b00;
      sync2  <= 2'b00;
      base   <= 2'b00;
      primed <= 1'b0;
    end else begin
      sync1  <= {phase_a, phase_b};
      sync2  <= sync1;
      base   <= sync2;
      primed <= 1'b1;
    end
  end

  always_comb begin
    dir_c = quad_dir(base, sync2);
    inc_c = primed && (dir_c == DIR_FWD);
    dec_c = primed && (dir_c == DIR_REV);
  end

endmodule

// File: rtl/gearbox.sv
// Electronic gearbox: scales quadrature counts by RATIO_NUM/RATIO_DEN into
// fixed-width step pulses for a stepper driver.
module gearbox
  import gearbox_pkg::*;
#(
  parameter int unsigned RATIO_NUM  = 3,
  parameter int unsigned RATIO_DEN  = 4,
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned PULSE_HIGH = 25,
  parameter int unsigned PULSE_LOW  = 25,
  parameter int unsigned PEND_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic phaseA,
  input  logic phaseB,
  output logic step_pulse
);

  localparam int unsigned TMR_MAX = (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic signed [ACC_W-1:0] NUM_S = ACC_W'(RATIO_NUM);
  localparam logic signed [ACC_W-1:0] DEN_S = ACC_W'(RATIO_DEN);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [TMR_W-1:0]  HIGH_LAST = TMR_W'(PULSE_HIGH - 1);
  localparam logic [TMR_W-1:0]  LOW_LAST  = TMR_W'(PULSE_LOW - 1);

  logic inc_c;
  logic dec_c;

  gearbox_quad_decoder u_quad_decoder (
    .clk     (clk),
    .rst_n   (rst_n),
    .phase_a (phaseA),
    .phase_b (phaseB),
    .inc_c   (inc_c),
    .dec_c   (dec_c)
  );

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum_c;
  logic signed [ACC_W-1:0] acc_next_c;
  logic                    busy_c;
  logic                    step_c;

  // The first DEN correction happens in the count cycle; any further ones
  // take one clock each with new counts held off until acc is back in range.
  always_comb begin
    busy_c     = (acc >= DEN_S) || acc[ACC_W-1];
    sum_c      = acc;
    if (!busy_c && inc_c) begin
      sum_c = acc + NUM_S;
    end else if (!busy_c && dec_c) begin
      sum_c = acc - NUM_S;
    end
    acc_next_c = sum_c;
    step_c     = 1'b0;
    if (sum_c >= DEN_S) begin
      acc_next_c = sum_c - DEN_S;
      step_c     = 1'b1;
    end else if (sum_c[ACC_W-1]) begin
      acc_next_c = sum_c + DEN_S;
      step_c     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else begin
      acc <= acc_next_c;
    end
  end

  logic [PEND_W-1:0] pending;
  logic              take_c;

  // Saturating step backlog; simultaneous add and take cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (step_c && !take_c) begin
      if (pending != PEND_MAX) pending <= pending + PEND_W'(1);
    end else if (!step_c && take_c) begin
      pending <= pending - PEND_W'(1);
    end
  end

  pulse_state_e     state;
  pulse_state_e     state_next;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_next;
  logic             pulse_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      step_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      step_pulse <= pulse_next;
    end
  end

  // A backlog goes straight from the end of LOW into the next HIGH.
  always_comb begin
    state_next = state;
    timer_next = timer + TMR_W'(1);
    take_c     = 1'b0;
    case (state)
      IDLE: begin
        timer_next = '0;
        if (pending != '0) begin
          state_next = HIGH;
          take_c     = 1'b1;
        end
      end
      HIGH: begin
        if (timer == HIGH_LAST) begin
          state_next = LOW;
          timer_next = '0;
        end
      end
      LOW: begin
        if (timer == LOW_LAST) begin
          timer_next = '0;
          if (pending != '0) begin
            state_next = HIGH;
            take_c     = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  always_comb begin
    pulse_next = (state_next == HIGH);
  end

endmodule

// File: tb/tb_gearbox.sv
// Bench for gearbox: three ratio configurations, a rational-arithmetic model
// for random traffic, a decode table and directed multi-cycle corner cases.
module tb_gearbox;

  localparam int PH = 25;
  localparam int PL = 25;

  logic       clk = 1'b0;
  logic       rst_n_a;
  logic       rst_n_b;
  logic [1:0] ab0;
  logic [1:0] ab1;
  logic [1:0] ab2;
  logic       sp0;
  logic       sp1;
  logic       sp2;

  always #20 clk = ~clk;

  gearbox #(.RATIO_NUM(3), .RATIO_DEN(4), .ACC_W(16), .PULSE_HIGH(PH), .PULSE_LOW(PL), .PEND_W(8))
    dut0 (.clk(clk), .rst_n(rst_n_a), .phaseA(ab0[1]), .phaseB(ab0[0]), .step_pulse(sp0));
  gearbox #(.RATIO_NUM(1), .RATIO_DEN(4), .ACC_W(16), .PULSE_HIGH(PH), .PULSE_LOW(PL), .PEND_W(8))
    dut1 (.clk(clk), .rst_n(rst_n_a), .phaseA(ab1[1]), .phaseB(ab1[0]), .step_pulse(sp1));
  gearbox #(.RATIO_NUM(8), .RATIO_DEN(1), .ACC_W(16), .PULSE_HIGH(PH), .PULSE_LOW(PL), .PEND_W(8))
    dut2 (.clk(clk), .rst_n(rst_n_b), .phaseA(ab2[1]), .phaseB(ab2[0]), .step_pulse(sp2));

  int checks   = 0;
  int failures = 0;

  int pulses  [3] = '{0, 0, 0};
  int bad_w   [3] = '{0, 0, 0};
  int bad_gap [3] = '{0, 0, 0};
  int hi      [3] = '{0, 0, 0};
  int lo      [3] = '{0, 0, 0};
  bit seen    [3] = '{0, 0, 0};
  bit sp_prev [3] = '{0, 0, 0};
  int max_pend2 = 0;
  int wrap2     = 0;
  int pend2_prev = 0;

  // Pulse monitor: counts rises, measures high width and low gap per instance.
  always @(negedge clk) begin
    logic [2:0] sp;
    logic [2:0] rs;
    sp = {sp2, sp1, sp0};
    rs = {rst_n_b, rst_n_a, rst_n_a};
    for (int i = 0; i < 3; i++) begin
      if (!rs[i]) begin
        sp_prev[i] = 1'b0; hi[i] = 0; lo[i] = 0; seen[i] = 1'b0;
      end else if (sp[i]) begin
        if (!sp_prev[i]) begin
          pulses[i]++;
          if (seen[i] && lo[i] < PL) bad_gap[i]++;
        end
        hi[i]++;
        sp_prev[i] = 1'b1;
      end else begin
        if (sp_prev[i]) begin
          if (hi[i] != PH) bad_w[i]++;
          hi[i] = 0; lo[i] = 0; seen[i] = 1'b1;
        end
        lo[i]++;
        sp_prev[i] = 1'b0;
      end
    end
    if (rst_n_b) begin
      if (int'(dut2.pending) > max_pend2) max_pend2 = int'(dut2.pending);
      if (pend2_prev > int'(dut2.pending) + 1) wrap2++;
    end
    pend2_prev = int'(dut2.pending);
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] gray(input int p);
    case (p)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic [1:0] v);
    @(negedge clk);
    case (d)
      0:       ab0 = v;
      1:       ab1 = v;
      default: ab2 = v;
    endcase
  endtask

  // Reference for the 3/4 instance: exact rational position bookkeeping.
  int macc = 0;
  int mexp = 0;
  int pos0 = 0;

  task automatic model_count(input int dir);
    if (dir > 0) begin
      macc += 3;
      while (macc >= 4) begin macc -= 4; mexp++; end
    end else begin
      macc -= 3;
      while (macc < 0) begin macc += 4; mexp++; end
    end
  endtask

  // kind: 0 forward edge, 1 reverse edge, 2 both channels toggle
  task automatic edge0(input int kind, input int gap);
    case (kind)
      0:       begin pos0 = (pos0 + 1) % 4; model_count(1);  end
      1:       begin pos0 = (pos0 + 3) % 4; model_count(-1); end
      default: pos0 = (pos0 + 2) % 4;
    endcase
    drive(0, gray(pos0));
    wait_cyc(gap);
  endtask

  typedef struct {
    logic [1:0] ab;
    int         exp;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int base;
    int mbase;
    int lat;
    int pos2;
    bit found;

    tbl[0]  = '{2'b10, 0}; tbl[1]  = '{2'b11, 0}; tbl[2]  = '{2'b01, 0};
    tbl[3]  = '{2'b00, 1}; tbl[4]  = '{2'b11, 1}; tbl[5]  = '{2'b01, 1};
    tbl[6]  = '{2'b00, 1}; tbl[7]  = '{2'b10, 1}; tbl[8]  = '{2'b11, 2};
    tbl[9]  = '{2'b10, 3}; tbl[10] = '{2'b00, 3}; tbl[11] = '{2'b01, 3};
    tbl[12] = '{2'b10, 3}; tbl[13] = '{2'b00, 3}; tbl[14] = '{2'b01, 4};

    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    ab0 = 'x; ab1 = 'x; ab2 = 'x;
    wait_cyc(5);
    check("reset_step_pulse", 64'({sp2, sp1, sp0}), 0);
    check("reset_acc", dut0.acc, 0);
    @(negedge clk);
    ab0 = 2'b00; ab1 = 2'b00; ab2 = 2'b00;
    wait_cyc(2);
    @(negedge clk);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    wait_cyc(100);
    check("x_start_no_pulse", pulses[0] + pulses[1] + pulses[2], 0);
    check("x_start_pending", dut0.pending, 0);

    // 100 forward quadrature cycles at 3/4
    base = pulses[0];
    for (int c = 0; c < 400; c++) edge0(0, 60);
    wait_cyc(200);
    check("fwd_pulses", pulses[0] - base, 300);
    check("fwd_width", bad_w[0], 0);
    check("fwd_gap", bad_gap[0], 0);

    // 100 reverse cycles bring the accumulator back to where it started
    base = pulses[0];
    for (int c = 0; c < 400; c++) edge0(1, 60);
    wait_cyc(200);
    check("rev_pulses", pulses[0] - base, 300);
    check("rev_acc_zero", dut0.acc, 0);
    check("rev_width", bad_w[0], 0);

    // Random walk with occasional illegal double toggles
    base  = pulses[0];
    mbase = mexp;
    for (int c = 0; c < 100; c++) begin
      int r;
      r = int'($urandom_range(0, 7));
      edge0((r == 0) ? 2 : ((r < 4) ? 0 : 1), int'($urandom_range(60, 90)));
    end
    wait_cyc(200);
    check("rand_pulses", pulses[0] - base, mexp - mbase);
    check("rand_acc", dut0.acc, macc);
    check("rand_width", bad_w[0] + bad_gap[0], 0);

    // 1/4: fourth edge yields the step, four clocks after the input change
    drive(1, 2'b10); wait_cyc(30);
    drive(1, 2'b11); wait_cyc(30);
    drive(1, 2'b01); wait_cyc(30);
    check("q1_no_early_pulse", pulses[1], 0);
    drive(1, 2'b00);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (sp1) begin lat = n; break; end
    end
    check("q1_latency", lat, 4);
    wait_cyc(60);
    check("q1_one_pulse", pulses[1], 1);

    base = pulses[1];
    for (int i = 0; i < 15; i++) begin
      drive(1, tbl[i].ab);
      wait_cyc(70);
      check($sformatf("tbl_%0d", i), pulses[1] - base, tbl[i].exp);
    end
    check("tbl_acc", dut1.acc, 3);
    check("tbl_width", bad_w[1] + bad_gap[1], 0);

    // 8/1 at 1us spacing: backlog builds, then drains without loss
    base = pulses[2];
    pos2 = 0;
    for (int c = 0; c < 20; c++) begin
      pos2 = (pos2 + 1) % 4;
      drive(2, gray(pos2));
      wait_cyc(24);
    end
    for (int n = 0; n < 9000 && (pulses[2] - base) < 160; n++) wait_cyc(1);
    wait_cyc(60);
    check("x8_pulses", pulses[2] - base, 160);
    check("x8_width", bad_w[2], 0);
    check("x8_gap", bad_gap[2], 0);

    for (int c = 0; c < 40; c++) begin
      pos2 = (pos2 + 1) % 4;
      drive(2, gray(pos2));
      wait_cyc(24);
    end
    check("sat_max", max_pend2, 255);
    check("sat_no_wrap", wrap2, 0);

    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (sp2) begin found = 1'b1; break; end
      wait_cyc(1);
    end
    check("pulse_before_reset", 64'(found), 1);
    wait_cyc(5);
    rst_n_b = 1'b0;
    #1;
    check("rst_drops_pulse", 64'(sp2), 0);
    check("rst_clears_pending", dut2.pending, 0);
    wait_cyc(3);
    rst_n_b = 1'b1;
    wait_cyc(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
